// File: rtl/counter_sched_ctrl.sv
// Shared WIDTH-bit counter driven by round-robin arbitrated commands.
// Exports the count, run status, wrap pulses and the last grant.
module counter_sched_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_cmd,
    input  logic [WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         cnt_value,
    output logic                     cnt_running,
    output logic                     wrap_pulse,
    output logic                     grant_valid,
    output logic [IDW-1:0]           grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_START = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gidx;
    logic             accept;
    logic [1:0]       sel_cmd;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        gidx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!accept && req_valid[j]) begin
                accept       = 1'b1;
                req_ready[j] = 1'b1;
                gidx         = IDW'(j);
            end
        end
    end

    assign sel_cmd  = req_cmd[2*int'(gidx) +: 2];
    assign sel_data = req_data[WIDTH*int'(gidx) +: WIDTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_value;
        wrap_nxt  = 1'b0;
        if (state == RUN) begin
            cnt_nxt  = cnt_value + WIDTH'(1);
            wrap_nxt = (cnt_value == '1);
        end
        if (accept) begin
            unique case (sel_cmd)
                CMD_CLEAR: begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b0;
                end
                CMD_LOAD: begin
                    cnt_nxt  = sel_data;
                    wrap_nxt = 1'b0;
                end
                CMD_START: begin
                    state_nxt = RUN;
                end
                CMD_STOP: begin
                    if (state == RUN) begin
                        state_nxt = IDLE;
                        cnt_nxt   = cnt_value;
                        wrap_nxt  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt_value   <= '0;
            wrap_pulse  <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            cnt_value   <= cnt_nxt;
            wrap_pulse  <= wrap_nxt;
            grant_valid <= accept;
            if (accept) begin
                grant_id <= gidx;
                rr_ptr   <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + IDW'(1);
            end
        end
    end

    assign cnt_running = (state == RUN);

endmodule

// File: doc/counter_sched_ctrl.md
Name: counter_sched_ctrl

Overview:
Shared controller for a WIDTH-bit free-running counter resource. Several requesters issue CLEAR/LOAD/START/STOP commands over valid/ready. A round-robin arbiter accepts at most one command per cycle. A two-state FSM sequences the counter and exports its value, run status and wrap events to consumers elsewhere in the hierarchy.

Parameters:
NUM_REQ, 4, number of command requesters (>=2)
WIDTH, 8, counter width in bits
IDW, $clog2(NUM_REQ), width of grant_id (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester command valid
req_cmd  input  2*NUM_REQ  per-requester command; slice i = [2*i+1:2*i]; 00 CLEAR, 01 LOAD, 10 START, 11 STOP
req_data  input  WIDTH*NUM_REQ  per-requester LOAD value; slice i = [WIDTH*i+WIDTH-1:WIDTH*i]
req_ready  output  NUM_REQ  one-hot grant, combinational from req_valid and rr pointer
cnt_value  output  WIDTH  registered counter value
cnt_running  output  1  registered, 1 in RUN state
wrap_pulse  output  1  registered one-cycle pulse when an increment wraps to 0
grant_valid  output  1  registered, 1 the cycle after a command was accepted
grant_id  output  IDW  registered index of last accepted requester

Behaviour:
- Reset (async assert, sync-safe deassert): cnt_value=0, cnt_running=0 (IDLE), wrap_pulse=0, grant_valid=0, grant_id=0, rr pointer=0. Reset mid-operation aborts everything immediately; in-flight commands are dropped.
- Arbitration: search starts at rr pointer, ascending mod NUM_REQ; first requester with req_valid gets req_ready=1. All others get 0. If none valid, req_ready=0.
- Acceptance = req_valid[i] & req_ready[i]. On acceptance of i, rr pointer <= (i+1) mod NUM_REQ. Without acceptance the pointer holds.
- Requesters hold valid/cmd/data stable until ready. Ready never depends on cmd.
- FSM states: IDLE and RUN.
  - IDLE: counter holds.
  - RUN: cnt_value += 1 each cycle, modulo 2^WIDTH.
- Command effect on the acceptance edge, overriding the increment on that edge:
  - CLEAR: cnt<=0; state unchanged; no wrap_pulse.
  - LOAD: cnt<=req_data slice; state unchanged; no wrap_pulse, even when loading 0.
  - START: IDLE->RUN; cnt unchanged on that edge; first increment on the following edge. START in RUN is a no-op, and the normal increment still happens.
  - STOP: RUN->IDLE; cnt holds its pre-edge value (no increment). STOP in IDLE is a no-op.
- wrap_pulse=1 for exactly the cycle in which cnt_value shows 0 as a result of an increment from 2^WIDTH-1; otherwise 0.
- grant_valid/grant_id: registered on the acceptance edge. grant_valid pulses for 1 cycle per accepted command. grant_id holds its last value when grant_valid=0.
- Latency: command accepted at edge N is visible on cnt_value/cnt_running after edge N. Back-to-back acceptances from different requesters are allowed every cycle.
- Simultaneous requests are served one per cycle in rr order; no requester waits more than NUM_REQ-1 acceptances.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, req_ready=0 with no valids; after release, rr pointer=0.
- Req0 START at edge N -> cnt_running=1 after N; cnt_value=0,1,2,3,4 at N, N+1..N+4; Req0 STOP -> cnt frozen, cnt_running=0.
- LOAD 8'hFD then START -> cnt FD,FE,FF,00 with wrap_pulse=1 only in the 00 cycle; LOAD 0 in IDLE -> wrap_pulse stays 0.
- All 4 requesters valid continuously with LOAD i -> grants 0,1,2,3,0 on consecutive cycles; grant_id matches; cnt_value follows loaded data.
- In RUN at cnt=8'h10, CLEAR accepted -> cnt=0 next cycle, then 1, 2; cnt_running stays 1.
- Async reset asserted while in RUN at cnt=8'h42 with req1 pending -> outputs 0 at once; after release, req1 is granted first (rr from 0, req0 idle).
